mdr_mem_if: RTL and testbench
=============================

# mdr_mem_if

Parametrised memory data register with a built-in memory handshake controller, the successor to the single-cycle MDR. It loads from the CPU bus or from memory, and drives byte/halfword/word transfers to the memory chip with lane alignment, sign/zero extension, wait-state handling and a timeout. It sits between the datapath bus and the memory port. The control unit issues one-cycle requests and waits for `done`.

## Interface
- `DATA_WIDTH`, 32: register/bus/memory data width; power of two, ≥16. LANES = DATA_WIDTH/8, OFS_W = clog2(LANES).
- `INIT`, 0: register value after reset.
- `WAIT_MAX`, 8: maximum wait edges for `mem_ready` before abort; ≥1. Counter width is clog2(WAIT_MAX+1).
- `clock` in 1: single clock; all state updates on the rising edge.
- `clear` in 1: asynchronous, active-low reset.
- `MDRin` in 1: load strobe.
- `read` in 1: with `MDRin`, the load source is memory; otherwise the source is `BusMuxOut`.
- `write` in 1: start a memory write of the register contents.
- `size` in 2: transfer size. 0 = byte, 1 = half, 2 = full width; 3 is treated as 2.
- `sign` in 1: sign-extend sub-width reads (0 = zero-extend).
- `offset` in OFS_W: low byte-address bits.
- `BusMuxOut` in DATA_WIDTH: bus data.
- `mem_rdata` in DATA_WIDTH: memory read data.
- `mem_ready` in 1: memory completes the current request.
- `BusMuxIn` out DATA_WIDTH: register contents to the bus.
- `mem_wdata` out DATA_WIDTH: lane-replicated write data.
- `mem_be` out LANES: byte enables.
- `mem_req` out 1: request active.
- `mem_we` out 1: request is a write.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: last operation was misaligned or timed out.

## Operation
- States: IDLE, RD_WAIT, WR_WAIT, DONE.
- **IDLE, command selection (priority order):**
  - `MDRin & read` → memory read.
  - else `write` → memory write.
  - else `MDRin` → q ← `BusMuxOut` (stays in IDLE, no `done`).
- **Memory start:**
  - `size`, `sign` and `offset` are latched at the start; later changes are ignored.
  - `err` is cleared.
- **Alignment:**
  - half requires `offset[0] = 0`; full requires `offset = 0`.
  - A misaligned start sets `err = 1` and goes directly to DONE. There is no `mem_req`, and q is unchanged.
- **Aligned read:** → RD_WAIT.
- **Aligned write:** → WR_WAIT.
- **Write data and enables:**
  - byte: `mem_wdata` = q[7:0] replicated LANES times; `mem_be` = 1 << offset.
  - half: `mem_wdata` = q[15:0] replicated; `mem_be` = 2'b11 << offset.
  - full: `mem_wdata` = q; `mem_be` = all ones.
  - In IDLE, `mem_be` = 0.
- **Wait states:**
  - `mem_req` = 1 throughout RD_WAIT and WR_WAIT; `mem_we` = 1 only in WR_WAIT.
  - On an edge with `mem_ready` = 1:
    - for a read, q ← extracted lane (byte/half at `offset`, extended by `sign`; full = `mem_rdata`);
    - then → DONE.
  - On an edge with `mem_ready` = 0, the wait counter increments. When the counter reaches WAIT_MAX: `err = 1`, → DONE, q unchanged.
  - If `mem_ready` is high on the same edge the counter reaches WAIT_MAX, ready wins and `err` stays 0.
- **DONE:** `done` = 1 for one cycle, → IDLE. Commands are ignored in DONE and in the WAIT states, including `MDRin` bus loads.
- **Reset:** `clear` = 0 at any time (including mid-transfer) immediately gives:
  - q = INIT, state IDLE, counter 0;
  - `mem_req` = `mem_we` = `busy` = `done` = `err` = 0, `mem_be` = 0.

## Timing
- All outputs are Moore (decoded from state and registers); there are no combinational paths from inputs to outputs. Exception: none.
- Bus load: q is visible on `BusMuxIn` the cycle after the `MDRin` edge.
- **Memory op, start accepted at edge N:**
  - `mem_req` is high from N.
  - If `mem_ready` is sampled high at edge N+k (k ≥ 1), q is updated at N+k, `done` is high between N+k and N+k+1, and `busy` falls at N+k+1.
  - Minimum start-to-`done` latency is 1 cycle; back-to-back throughput is one op per k+2 cycles.
- Timeout: with `mem_ready` held low, `done` and `err` rise after edge N+WAIT_MAX.
- Misaligned op: `done` and `err` are high the cycle after N, with no `mem_req` pulse.
- `mem_rdata` is sampled only on an edge where state = RD_WAIT and `mem_ready` = 1.

## Test plan
- **Reset:** assert `clear` = 0 asynchronously between edges → `BusMuxIn` = INIT, all handshake outputs 0, without waiting for an edge. Then release, apply `MDRin` with `BusMuxOut` = 0xDEADBEEF → `BusMuxIn` = 0xDEADBEEF next cycle, `done` stays 0.
- **Signed byte read:** read with size 0, sign 1, offset 2, `mem_rdata` = 0x12F0_3456, `mem_ready` after 3 wait cycles → q = 0xFFFFFFF0, `done` pulse 4 cycles after start, `err` = 0. Repeat with sign 0 → 0x000000F0.
- **Half write:** q = 0x0000_ABCD, write with size 1, offset 2 → `mem_wdata` = 0xABCDABCD, `mem_be` = 4'b1100, `mem_we` = 1 until `mem_ready`, then a one-cycle `done`.
- **Misaligned and priority:**
  - full read with offset 1 → `err` = 1 and `done` the next cycle, no `mem_req`, q unchanged;
  - `read & MDRin & write` together → read performed.
- **Timeout boundary:** WAIT_MAX = 8 with `mem_ready` never high → `err` and `done` after 8 wait edges, q unchanged. `mem_ready` first high exactly on edge 8 → successful read, `err` = 0.
- **Reset mid-transfer:** drop `clear` during WR_WAIT → `mem_req`/`mem_we` drop immediately and q = INIT. The next read after release completes normally.

Source files
------------

// File: rtl/mdr_mem_if_if.sv
// mdr_mem_if_if: groups the bus and memory-port signals of mdr_mem_if.
//
// Parameters: DATA_WIDTH (register/bus/memory width, power of two, >= 16).
// Modports:
//   slave  - the mdr_mem_if block itself. It takes the command and bus inputs
//            and drives BusMuxIn and the memory request side.
//   master - the environment: the control unit, the datapath bus and the
//            memory chip.
// Signals:
//   MDRin, read, write, size[1:0], sign, offset[OFS_W-1:0] : command inputs
//   BusMuxOut, mem_rdata, mem_ready                        : data/handshake inputs
//   BusMuxIn, mem_wdata, mem_be, mem_req, mem_we           : data/request outputs
//   busy, done, err                                        : status outputs
interface mdr_mem_if_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(LANES);

  logic                  MDRin;
  logic                  read;
  logic                  write;
  logic [1:0]            size;
  logic                  sign;
  logic [OFS_W-1:0]      offset;
  logic [DATA_WIDTH-1:0] BusMuxOut;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  logic [DATA_WIDTH-1:0] BusMuxIn;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_be;
  logic                  mem_req;
  logic                  mem_we;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output MDRin, read, write, size, sign, offset, BusMuxOut, mem_rdata, mem_ready,
    input  BusMuxIn, mem_wdata, mem_be, mem_req, mem_we, busy, done, err
  );

  modport slave (
    input  MDRin, read, write, size, sign, offset, BusMuxOut, mem_rdata, mem_ready,
    output BusMuxIn, mem_wdata, mem_be, mem_req, mem_we, busy, done, err
  );
endinterface

// File: rtl/mdr_mem_if.sv
// mdr_mem_if: memory data register with a built-in memory handshake controller.
//
// The register q loads either from the CPU bus (BusMuxOut) or from memory.
// Memory transfers can be byte, halfword or full width. They use byte-lane
// alignment, sign/zero extension on reads, wait states and a timeout.
//
// Parameters:
//   DATA_WIDTH : register/bus/memory width (power of two, >= 16)
//   INIT       : value of q after reset
//   WAIT_MAX   : number of mem_ready-low edges tolerated before abort (>= 1)
// Ports:
//   clock     : rising-edge clock
//   clear     : asynchronous active-low reset
//   bus       : mdr_mem_if_if.slave. Holds the command inputs, the bus data and
//               the memory port.
//   dbg_state : current controller state (IDLE=0, RD_WAIT=1, WR_WAIT=2, DONE=3)
//
// Handshake: the control unit issues a command as a one-cycle strobe while the
// controller is idle. The controller then holds mem_req (and mem_we, mem_be,
// mem_wdata) steady until it samples mem_ready high on a rising edge. That edge
// completes the transfer. A read captures mem_rdata only on that edge. done
// pulses for exactly one cycle afterwards. Commands arriving while busy are
// dropped, not queued.
module mdr_mem_if #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter int                    WAIT_MAX   = 8
) (
  input  logic        clock,
  input  logic        clear,
  mdr_mem_if_if.slave bus,
  output logic [1:0]  dbg_state
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS_W = $clog2(LANES);
  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] q;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            size_r;
  logic                  sign_r;
  logic [OFS_W-1:0]      ofs_r;
  logic                  err_r;
  logic                  done_r;
  logic                  req_r;
  logic                  we_r;
  logic [LANES-1:0]      be_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  // ---------------------------------------------------------------------------
  // Start-of-transfer decode from the live command inputs
  // ---------------------------------------------------------------------------
  logic                  start_rd;
  logic                  start_mem;
  logic [1:0]            size_in;
  logic                  misaligned;
  logic [LANES-1:0]      be_in;
  logic [DATA_WIDTH-1:0] wdata_in;

  assign start_rd  = bus.MDRin && bus.read;
  assign start_mem = start_rd || bus.write;
  // size 3 is an alias of full width
  assign size_in   = (bus.size == 2'd3) ? 2'd2 : bus.size;

  always_comb begin
    misaligned = 1'b0;
    be_in      = '1;
    wdata_in   = q;
    case (size_in)
      2'd0: begin
        be_in    = LANES'(1) << bus.offset;
        wdata_in = {LANES{q[7:0]}};
      end
      2'd1: begin
        misaligned = bus.offset[0];
        be_in      = LANES'(3) << bus.offset;
        wdata_in   = {(LANES / 2){q[15:0]}};
      end
      default: begin
        misaligned = |bus.offset;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read lane extraction, using the size/sign/offset latched at start
  // ---------------------------------------------------------------------------
  logic [OFS_W+2:0]      bit_ofs;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [DATA_WIDTH-1:0] rd_ext;

  assign bit_ofs = {ofs_r, 3'b000};
  assign rd_byte = 8'(bus.mem_rdata >> bit_ofs);
  assign rd_half = 16'(bus.mem_rdata >> bit_ofs);

  always_comb begin
    rd_ext = bus.mem_rdata;
    case (size_r)
      2'd0:    rd_ext = {{(DATA_WIDTH - 8){sign_r & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{(DATA_WIDTH - 16){sign_r & rd_half[15]}}, rd_half};
      default: rd_ext = bus.mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Controller FSM and registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      q       <= INIT;
      cnt     <= '0;
      size_r  <= 2'd0;
      sign_r  <= 1'b0;
      ofs_r   <= '0;
      err_r   <= 1'b0;
      done_r  <= 1'b0;
      req_r   <= 1'b0;
      we_r    <= 1'b0;
      be_r    <= '0;
      wdata_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mem) begin
            size_r <= size_in;
            sign_r <= bus.sign;
            ofs_r  <= bus.offset;
            cnt    <= '0;
            if (misaligned) begin
              // No memory request is issued. Report the error and finish now.
              err_r  <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              err_r <= 1'b0;
              req_r <= 1'b1;
              be_r  <= be_in;
              if (start_rd) begin
                state <= RD_WAIT;
              end else begin
                we_r    <= 1'b1;
                wdata_r <= wdata_in;
                state   <= WR_WAIT;
              end
            end
          end else if (bus.MDRin) begin
            q <= bus.BusMuxOut;
          end
        end

        RD_WAIT, WR_WAIT: begin
          if (bus.mem_ready) begin
            // Ready wins even on the edge where the counter would expire.
            if (state == RD_WAIT) q <= rd_ext;
            req_r  <= 1'b0;
            we_r   <= 1'b0;
            be_r   <= '0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WAIT_MAX - 1)) begin
              err_r  <= 1'b1;
              req_r  <= 1'b0;
              we_r   <= 1'b0;
              be_r   <= '0;
              done_r <= 1'b1;
              state  <= DONE;
            end
          end
        end

        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.BusMuxIn  = q;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_be    = be_r;
  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_mdr_mem_if.sv
// tb_mdr_mem_if: self-checking bench for mdr_mem_if (DATA_WIDTH=32, WAIT_MAX=8).
module tb_mdr_mem_if;

  localparam int          DW       = 32;
  localparam int          WAIT_MAX = 8;
  localparam logic [31:0] INIT_VAL = 32'hA5A5_0F0F;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  mdr_mem_if_if #(.DATA_WIDTH(DW)) bus ();

  mdr_mem_if #(
    .DATA_WIDTH(DW),
    .INIT      (INIT_VAL),
    .WAIT_MAX  (WAIT_MAX)
  ) dut (
    .clock    (clk),
    .clear    (clear),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_q;
  logic        model_err;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge: inputs are driven and outputs
  // sampled at this point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ext_read(input logic [31:0] rdata, input int nbytes,
                                           input bit sgn, input int ofs);
    longint unsigned v;
    longint unsigned mask;
    v    = rdata;
    v    = v >> (8 * ofs);
    mask = (64'd1 << (8 * nbytes)) - 64'd1;
    v    = v & mask;
    if (sgn && (((v >> (8 * nbytes - 1)) & 64'd1) == 64'd1)) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    bus.MDRin     = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.size      = 2'd0;
    bus.sign      = 1'b0;
    bus.offset    = 2'd0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic bus_load(input logic [31:0] val);
    bus.MDRin     = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.BusMuxOut = val;
    tick();
    bus.MDRin = 1'b0;
    model_q   = val;
    chk("bus_load_q", bus.BusMuxIn, val);
    chk("bus_load_done", bus.done, 1'b0);
  endtask

  // One memory operation, checked cycle by cycle against the model.
  // ready_edge = k means mem_ready is high on edge N+k; any value outside
  // 1..WAIT_MAX means mem_ready never rises (timeout).
  task automatic run_op(input string tag, input bit is_wr, input bit also_wr,
                        input logic [1:0] sz, input bit sgn, input logic [1:0] ofs,
                        input logic [31:0] rdata, input int ready_edge);
    int          nb;
    bit          aligned;
    bit          tmo;
    int          last;
    logic [31:0] exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] q_exp;

    nb      = size_bytes(sz);
    aligned = ((ofs % nb) == 0);
    tmo     = (ready_edge < 1) || (ready_edge > WAIT_MAX);
    last    = tmo ? WAIT_MAX : ready_edge;
    for (int i = 0; i < 4; i++) begin
      exp_wd[8*i +: 8] = model_q[8*(i % nb) +: 8];
      exp_be[i]        = (i >= ofs) && (i < ofs + nb);
    end
    if (aligned && !is_wr && !tmo) q_exp = ext_read(rdata, nb, sgn, ofs);
    else                           q_exp = model_q;
    exp_q.push_back(q_exp);

    // start edge N
    bus.MDRin     = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.read      = !is_wr;
    bus.write     = is_wr || also_wr;
    bus.size      = sz;
    bus.sign      = sgn;
    bus.offset    = ofs;
    bus.BusMuxOut = $urandom;
    bus.mem_ready = 1'b0;
    tick();
    // size/sign/offset must be latched: scramble them from now on
    bus.size   = 2'($urandom_range(0, 3));
    bus.sign   = 1'($urandom_range(0, 1));
    bus.offset = 2'($urandom_range(0, 3));

    if (!aligned) begin
      bus.MDRin = 1'b0; bus.read = 1'b0; bus.write = 1'b0;
      chk({tag, "_mis_done"}, bus.done, 1'b1);
      chk({tag, "_mis_err"}, bus.err, 1'b1);
      chk({tag, "_mis_req"}, bus.mem_req, 1'b0);
      model_err = 1'b1;
    end else begin
      for (int j = 1; j <= last; j++) begin
        chk({tag, "_req"}, bus.mem_req, 1'b1);
        chk({tag, "_we"}, bus.mem_we, is_wr);
        chk({tag, "_busy"}, bus.busy, 1'b1);
        chk({tag, "_early_done"}, bus.done, 1'b0);
        chk({tag, "_err_clr"}, bus.err, 1'b0);
        if (is_wr) begin
          chk({tag, "_wdata"}, bus.mem_wdata, exp_wd);
          chk({tag, "_be"}, bus.mem_be, exp_be);
        end
        // junk commands during the wait must be ignored
        bus.MDRin     = 1'($urandom_range(0, 1));
        bus.read      = 1'($urandom_range(0, 1));
        bus.write     = 1'($urandom_range(0, 1));
        bus.BusMuxOut = $urandom;
        bus.mem_ready = (j == ready_edge);
        bus.mem_rdata = (j == ready_edge) ? rdata : 32'($urandom);
        tick();
      end
      chk({tag, "_done"}, bus.done, 1'b1);
      chk({tag, "_err"}, bus.err, tmo);
      chk({tag, "_req_off"}, bus.mem_req, 1'b0);
      model_err = tmo;
    end

    // DONE cycle: a bus load here must be ignored
    model_q       = exp_q.pop_front();
    chk({tag, "_q"}, bus.BusMuxIn, model_q);
    bus.mem_ready = 1'b0;
    bus.MDRin     = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.BusMuxOut = $urandom;
    tick();
    idle_inputs();
    chk({tag, "_done_off"}, bus.done, 1'b0);
    chk({tag, "_idle"}, bus.busy, 1'b0);
    chk({tag, "_be_idle"}, bus.mem_be, 4'b0000);
    chk({tag, "_err_hold"}, bus.err, model_err);
    chk({tag, "_q_hold"}, bus.BusMuxIn, model_q);
  endtask

  // ---------------------------------------------------------------------------
  // Directed + random sequence
  // ---------------------------------------------------------------------------
  initial begin
    idle_inputs();
    bus.BusMuxOut = '0;
    bus.mem_rdata = '0;
    model_q       = INIT_VAL;
    model_err     = 1'b0;
    clear         = 1'b1;

    // asynchronous reset with no clock edge yet
    #2 clear = 1'b0;
    #1;
    chk("rst_q", bus.BusMuxIn, INIT_VAL);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_we", bus.mem_we, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_be", bus.mem_be, 4'b0000);
    tick();
    tick();
    clear = 1'b1;

    bus_load(32'hDEAD_BEEF);

    // async reset between edges
    #2 clear = 1'b0;
    #1;
    chk("arst_q", bus.BusMuxIn, INIT_VAL);
    chk("arst_busy", bus.busy, 1'b0);
    tick();
    clear   = 1'b1;
    model_q = INIT_VAL;

    bus_load(32'hDEAD_BEEF);

    // signed / unsigned byte read, ready after 3 wait cycles
    run_op("rd_sb", 1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 32'h12F0_3456, 4);
    chk("rd_sb_val", model_q, 32'hFFFF_FFF0);
    run_op("rd_ub", 1'b0, 1'b0, 2'd0, 1'b0, 2'd2, 32'h12F0_3456, 4);
    chk("rd_ub_val", model_q, 32'h0000_00F0);

    // half write at offset 2
    bus_load(32'h0000_ABCD);
    run_op("wr_h", 1'b1, 1'b0, 2'd1, 1'b0, 2'd2, 32'h0, 2);

    // misaligned full read and half read
    run_op("mis_f", 1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 32'h1111_1111, 1);
    run_op("mis_h", 1'b0, 1'b0, 2'd1, 1'b1, 2'd3, 32'h2222_2222, 1);

    // read & MDRin & write together: read wins
    run_op("prio", 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 32'h7654_3210, 1);

    // timeout, and ready exactly on the last allowed edge
    run_op("tmo", 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 32'h0BAD_F00D, 0);
    run_op("rdy8", 1'b0, 1'b0, 2'd1, 1'b1, 2'd2, 32'h8001_0000, WAIT_MAX);

    // reset during WR_WAIT
    bus_load(32'h1234_5678);
    bus.write = 1'b1; bus.size = 2'd2; bus.offset = 2'd0;
    tick();
    idle_inputs();
    tick();
    tick();
    #2 clear = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 1'b0);
    chk("mid_rst_we", bus.mem_we, 1'b0);
    chk("mid_rst_q", bus.BusMuxIn, INIT_VAL);
    chk("mid_rst_be", bus.mem_be, 4'b0000);
    chk("mid_rst_busy", bus.busy, 1'b0);
    tick();
    clear     = 1'b1;
    model_q   = INIT_VAL;
    model_err = 1'b0;
    run_op("post_rst", 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 32'h0000_8000, 2);

    // randomized mix
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r == 0) bus_load($urandom);
      else run_op("rnd", (r == 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                  $urandom_range(0, WAIT_MAX + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
